// File: rtl/fwrisc_fetch.sv
// fwrisc_fetch: instruction-fetch stage. Holds the PC, reads instruction words and presents one
// instruction at a time to decode. Define FWRISC_FETCH_COMPRESSED_EN for 16-bit instruction support.
module fwrisc_fetch #(
  parameter logic [31:0] RESET_VECTOR = 32'h8000_0000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        next_pc_valid,
  output logic [31:0] iaddr,
  input  logic [31:0] idata,
  output logic        ivalid,
  input  logic        iready,
  output logic        fetch_valid,
  input  logic        decode_ready,
  output logic [31:0] instr,
  output logic        instr_c,
  output logic [31:0] pc
);

  typedef enum logic [2:0] {
    S_RESET,
    S_FETCH,
`ifdef FWRISC_FETCH_COMPRESSED_EN
    S_FETCH_HI,
`endif
    S_HOLD,
    S_WAIT_PC
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_q, pc_nxt;
  logic [31:0] instr_q, instr_nxt;
  logic        instr_c_q, instr_c_nxt;
  logic [31:0] next_pc_aligned;

`ifdef FWRISC_FETCH_COMPRESSED_EN
  logic        buf_valid, buf_valid_nxt;
  logic [29:0] buf_tag, buf_tag_nxt;
  logic [31:0] buf_word, buf_word_nxt;
  logic        buf_hit;
  logic [31:0] fetch_word;
  logic [15:0] fetch_half;

  assign next_pc_aligned = next_pc & 32'hFFFF_FFFE;
  assign buf_hit         = buf_valid && (buf_tag == pc_q[31:2]);
  assign fetch_word      = buf_hit ? buf_word : idata;
  assign fetch_half      = pc_q[1] ? fetch_word[31:16] : fetch_word[15:0];
`else
  assign next_pc_aligned = next_pc & 32'hFFFF_FFFC;
`endif

  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_c     = instr_c_q;
  assign fetch_valid = (state == S_HOLD);

  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc_q;
    instr_nxt   = instr_q;
    instr_c_nxt = instr_c_q;
    ivalid      = 1'b0;
    iaddr       = {pc_q[31:2], 2'b00};
`ifdef FWRISC_FETCH_COMPRESSED_EN
    buf_valid_nxt = buf_valid;
    buf_tag_nxt   = buf_tag;
    buf_word_nxt  = buf_word;
`endif
    case (state)
      // RESET behaves as FETCH from the first cycle reset is low, so the bus request is not delayed
      S_RESET, S_FETCH: begin
        if (state == S_RESET && reset) begin
          iaddr = '0;
        end else begin
`ifdef FWRISC_FETCH_COMPRESSED_EN
          ivalid = !buf_hit;
          if (buf_hit || iready) begin
            if (!buf_hit) begin
              buf_valid_nxt = 1'b1;
              buf_tag_nxt   = pc_q[31:2];
              buf_word_nxt  = idata;
            end
            if (fetch_half[1:0] != 2'b11) begin
              instr_nxt   = {16'h0000, fetch_half};
              instr_c_nxt = 1'b1;
              state_nxt   = S_HOLD;
            end else if (!pc_q[1]) begin
              instr_nxt   = fetch_word;
              instr_c_nxt = 1'b0;
              state_nxt   = S_HOLD;
            end else begin
              state_nxt = S_FETCH_HI;
            end
          end
`else
          ivalid = 1'b1;
          if (iready) begin
            instr_nxt   = idata;
            instr_c_nxt = 1'b0;
            state_nxt   = S_HOLD;
          end
`endif
        end
      end
`ifdef FWRISC_FETCH_COMPRESSED_EN
      // Lower half already sits in the buffer; the upper half comes from the following word
      S_FETCH_HI: begin
        ivalid = 1'b1;
        iaddr  = {pc_q[31:2] + 30'd1, 2'b00};
        if (iready) begin
          instr_nxt     = {idata[15:0], buf_word[31:16]};
          instr_c_nxt   = 1'b0;
          buf_valid_nxt = 1'b1;
          buf_tag_nxt   = pc_q[31:2] + 30'd1;
          buf_word_nxt  = idata;
          state_nxt     = S_HOLD;
        end
      end
`endif
      S_HOLD: begin
        if (decode_ready) begin
          if (next_pc_valid) begin
            pc_nxt    = next_pc_aligned;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WAIT_PC;
          end
        end
      end
      S_WAIT_PC: begin
        if (next_pc_valid) begin
          pc_nxt    = next_pc_aligned;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_RESET;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_RESET;
      pc_q      <= RESET_VECTOR;
      instr_q   <= '0;
      instr_c_q <= 1'b0;
`ifdef FWRISC_FETCH_COMPRESSED_EN
      buf_valid <= 1'b0;
      buf_tag   <= '0;
      buf_word  <= '0;
`endif
    end else begin
      state     <= state_nxt;
      pc_q      <= pc_nxt;
      instr_q   <= instr_nxt;
      instr_c_q <= instr_c_nxt;
`ifdef FWRISC_FETCH_COMPRESSED_EN
      buf_valid <= buf_valid_nxt;
      buf_tag   <= buf_tag_nxt;
      buf_word  <= buf_word_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_fwrisc_fetch.sv
// Randomized self-checking bench for fwrisc_fetch against a memory/halfword-level reference model.
module tb_fwrisc_fetch;
  localparam logic [31:0] RV = 32'h8000_0000;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] next_pc;
  logic        next_pc_valid;
  logic [31:0] iaddr;
  logic [31:0] idata;
  logic        ivalid;
  logic        iready;
  logic        fetch_valid;
  logic        decode_ready;
  logic [31:0] instr;
  logic        instr_c;
  logic [31:0] pc;

  always #5 clock = ~clock;

  fwrisc_fetch #(.RESET_VECTOR(RV)) dut (
    .clock(clock), .reset(reset), .next_pc(next_pc), .next_pc_valid(next_pc_valid),
    .iaddr(iaddr), .idata(idata), .ivalid(ivalid), .iready(iready),
    .fetch_valid(fetch_valid), .decode_ready(decode_ready),
    .instr(instr), .instr_c(instr_c), .pc(pc)
  );

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  logic [31:0] mem [0:63];
  bit          m_valid;
  logic [31:0] m_tag;
  logic [31:0] cur_pc, cur_instr;
  logic        cur_c;
  int unsigned cur_len;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] off;
    off = a - RV;
    if (off < 32'd256) return mem[off[7:2]];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic logic [15:0] mem16(input logic [31:0] a);
    logic [31:0] w;
    w = mem_rd(a);
    return a[1] ? w[31:16] : w[15:0];
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
`ifdef FWRISC_FETCH_COMPRESSED_EN
    return {a[31:1], 1'b0};
`else
    return {a[31:2], 2'b00};
`endif
  endfunction

  // Entered mid-cycle while the DUT is fetching pc_exp; returns with fetch_valid seen.
  task automatic run_fetch(input logic [31:0] pc_exp, input int fixed_waits);
    logic [31:0] exp_q[$];
    logic [31:0] wa, paddr;
    logic [15:0] h0;
    bit hit, pend, done;
    int cyc, waits, nreads, wcount;
    cyc = 0; waits = 0; nreads = 0; wcount = 0; pend = 0; done = 0; paddr = '0;
    wa = {pc_exp[31:2], 2'b00};
`ifdef FWRISC_FETCH_COMPRESSED_EN
    h0 = mem16(pc_exp);
    hit = m_valid && (m_tag == wa);
    if (!hit) exp_q.push_back(wa);
    if (h0[1:0] != 2'b11) begin
      cur_instr = {16'h0000, h0}; cur_c = 1'b1; cur_len = 2;
    end else begin
      cur_instr = {mem16(pc_exp + 32'd2), h0}; cur_c = 1'b0; cur_len = 4;
      if (pc_exp[1]) exp_q.push_back(wa + 32'd4);
    end
    if (exp_q.size() > 0) begin m_valid = 1'b1; m_tag = exp_q[$]; end
`else
    h0 = '0;
    hit = 1'b0;
    exp_q.push_back(wa);
    cur_instr = mem_rd(wa); cur_c = 1'b0; cur_len = 4;
`endif
    cur_pc = pc_exp;
    for (int c = 0; c < 64 && !done; c++) begin
      if (fetch_valid) begin
        done = 1'b1;
      end else begin
        cyc++;
        if (pend) begin
          check_eq("ivalid_hold", ivalid, 1);
          check_eq("iaddr_hold", iaddr, paddr);
        end
        next_pc_valid = ($urandom_range(0, 3) == 0);
        next_pc       = $urandom;
        decode_ready  = 1'($urandom_range(0, 1));
        if (ivalid) begin
          if (nreads < exp_q.size()) check_eq("iaddr", iaddr, exp_q[nreads]);
          if ((fixed_waits >= 0) ? (wcount < fixed_waits) : ($urandom_range(0, 2) == 0)) begin
            iready = 1'b0; idata = $urandom; pend = 1'b1; paddr = iaddr; waits++; wcount++;
          end else begin
            iready = 1'b1; idata = mem_rd(iaddr); pend = 1'b0; nreads++; wcount = 0;
          end
        end else begin
          pend = 1'b0;
          iready = 1'($urandom_range(0, 1));
          idata = $urandom;
        end
        @(negedge clock);
      end
    end
    next_pc_valid = 1'b0; decode_ready = 1'b0; iready = 1'b0;
    check_eq("fetch_valid", fetch_valid, 1);
    check_eq("nreads", nreads, exp_q.size());
    check_eq("latency", cyc, waits + nreads + (hit ? 1 : 0));
    check_eq("pc", pc, cur_pc);
    check_eq("instr", instr, cur_instr);
    check_eq("instr_c", instr_c, cur_c);
  endtask

  // Holds in HOLD, retires the instruction and supplies npc (same cycle or via WAIT_PC).
  task automatic hold_and_advance(input logic [31:0] npc, input bit same);
    int h, w;
    h = $urandom_range(0, 3);
    for (int i = 0; i < h; i++) begin
      decode_ready = 1'b0; next_pc_valid = 1'($urandom_range(0, 1)); next_pc = $urandom;
      @(negedge clock);
      check_eq("hold_valid", fetch_valid, 1);
      check_eq("hold_pc", pc, cur_pc);
      check_eq("hold_instr", instr, cur_instr);
    end
    decode_ready = 1'b1; next_pc_valid = same; next_pc = npc;
    @(negedge clock);
    decode_ready = 1'b0; next_pc_valid = 1'b0;
    check_eq("fv_drop", fetch_valid, 0);
    if (!same) begin
      check_eq("wait_ivalid", ivalid, 0);
      w = $urandom_range(0, 3);
      for (int i = 0; i < w; i++) begin
        decode_ready = 1'($urandom_range(0, 1));
        @(negedge clock);
        check_eq("wait_ivalid", ivalid, 0);
        check_eq("wait_fv", fetch_valid, 0);
      end
      decode_ready = 1'b0; next_pc_valid = 1'b1; next_pc = npc;
      @(negedge clock);
      next_pc_valid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0] w, npc, rpc;
    reset = 1'b1; iready = 1'b0; idata = '0; next_pc = '0; next_pc_valid = 1'b0; decode_ready = 1'b0;
    for (int i = 0; i < 64; i++) begin
      w = $urandom;
      if ($urandom_range(0, 1) == 1) w[1:0] = 2'b11;
      if ($urandom_range(0, 1) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
    mem[0]  = 32'h0000_0013;
    mem[40] = 32'h4501_4505;
    mem[42] = 32'h0093_0000;
    mem[43] = 32'h1234_0000;
    m_valid = 1'b0; m_tag = '0;

    repeat (3) @(negedge clock);
    check_eq("rst_ivalid", ivalid, 0);
    check_eq("rst_iaddr", iaddr, 0);
    check_eq("rst_fv", fetch_valid, 0);
    check_eq("rst_instr", instr, 0);
    check_eq("rst_instr_c", instr_c, 0);
    check_eq("rst_pc", pc, RV);
    reset = 1'b0;
    #1;
    run_fetch(RV, 0);

    hold_and_advance(32'h8000_0004, 1'b1);
    run_fetch(32'h8000_0004, 5);
    hold_and_advance(32'h8000_00A0, 1'b0);
    run_fetch(align(32'h8000_00A0), -1);
    hold_and_advance(32'h8000_00A2, 1'b0);
    run_fetch(align(32'h8000_00A2), -1);
    hold_and_advance(32'h8000_00AA, 1'b1);
    run_fetch(align(32'h8000_00AA), -1);

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 1) == 1) npc = cur_pc + cur_len | 32'($urandom_range(0, 1));
      else npc = RV + ($urandom_range(0, 62) << 2) + $urandom_range(0, 3);
      hold_and_advance(npc, 1'($urandom_range(0, 1)));
      run_fetch(align(npc), -1);
    end

    rpc = (m_valid && m_tag == RV + 32'h80) ? RV + 32'h84 : RV + 32'h80;
    hold_and_advance(rpc, 1'b0);
    check_eq("pre_rst_ivalid", ivalid, 1);
    reset = 1'b1; iready = 1'b1; idata = mem_rd(iaddr);
    @(negedge clock);
    check_eq("mid_rst_ivalid", ivalid, 0);
    check_eq("mid_rst_fv", fetch_valid, 0);
    check_eq("mid_rst_pc", pc, RV);
    check_eq("mid_rst_iaddr", iaddr, 0);
    check_eq("mid_rst_instr", instr, 0);
    check_eq("mid_rst_instr_c", instr_c, 0);
    iready = 1'b0; m_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    run_fetch(RV, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/fwrisc_fetch.md
# fwrisc_fetch

Instruction-fetch stage for the FWRISC core, directly upstream of `fwrisc_decode`. Holds the program counter and issues word reads on the instruction bus. Presents one instruction at a time to decode over the `fetch_valid`/`decode_ready` handshake, then waits for exec to supply the next PC. Optionally handles 16-bit compressed instructions using a one-word fetch buffer.

## Interface
- `RESET_VECTOR`, default 32'h8000_0000: PC loaded on reset.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `next_pc`  in  32: address of the next instruction, from exec.
- `next_pc_valid`  in  1: single-cycle strobe qualifying `next_pc`.
- `iaddr`  out  32: instruction-bus word address; bits [1:0] are always 0.
- `idata`  in  32: read data, valid in the `ivalid && iready` cycle.
- `ivalid`  out  1: bus request.
- `iready`  in  1: bus accept/complete.
- `fetch_valid`  out  1: `instr`/`instr_c`/`pc` are valid for decode.
- `decode_ready`  in  1: decode has consumed the instruction (the decode block's `decode_complete`).
- `instr`  out  32: instruction word; compressed instructions are zero-extended in [15:0].
- `instr_c`  out  1: `instr` is a 16-bit compressed instruction.
- `pc`  out  32: address of the presented instruction.

## Operation
- States:
  - RESET
  - FETCH: bus read for the low part.
  - FETCH_HI: bus read for the upper half of a split instruction; compressed builds only.
  - HOLD: `fetch_valid`=1.
  - WAIT_PC
- RESET: entered while `reset`=1.
  - Outputs during reset: `pc`=RESET_VECTOR, `ivalid`=0, `iaddr`=0, `fetch_valid`=0, `instr`=0, `instr_c`=0.
  - Fetch buffer is invalidated.
  - Goes to FETCH in the first cycle with `reset`=0.
- FETCH: `ivalid`=1, `iaddr`={pc[31:2],2'b00}.
  - `ivalid` and `iaddr` are held stable until `iready`.
  - On `ivalid && iready`: capture `idata` into the fetch buffer (word and address tag) and form `instr`.
  - Then go to HOLD, or to FETCH_HI for a split 32-bit instruction.
- HOLD: `fetch_valid`=1; `instr`, `instr_c` and `pc` are stable.
  - On `decode_ready`=1: go to WAIT_PC, or directly to FETCH if `next_pc_valid`=1 in the same cycle (PC loaded from `next_pc`).
- WAIT_PC: on `next_pc_valid`: pc <= `next_pc` (bits [1:0] handled per Configuration), then go to FETCH.
- Ignored inputs:
  - `next_pc_valid` in FETCH/FETCH_HI, and in HOLD without `decode_ready`.
  - `decode_ready` outside HOLD.
- Reset mid-transaction:
  - `ivalid` drops in the following cycle.
  - A concurrent `iready` is discarded.
  - The buffer is invalidated.

## Timing
- Reset release to first `ivalid`: same cycle as the first `reset`=0 cycle.
- `ivalid && iready` at cycle N gives `fetch_valid`=1 at N+1 (compressed, non-split case).
- `decode_ready` sampled high at N gives `fetch_valid`=0 at N+1.
- `next_pc_valid` at N gives `ivalid`=1 at N+1 on a buffer miss.
  - On a buffer hit (compressed builds), no bus cycle occurs and `fetch_valid`=1 at N+2.
- Bus wait states: unlimited; all outputs hold.

## Configuration
- `FWRISC_FETCH_COMPRESSED_EN` defined:
  - PC is halfword-aligned: `next_pc[0]` is forced to 0, `next_pc[1]` is kept.
  - The selected halfword is bits [15:0] when pc[1]=0 and bits [31:16] when pc[1]=1.
  - `instr_c` = (halfword[1:0] != 2'b11).
  - Split instruction (pc[1]=1 and 32-bit):
    - Upper half comes from word pc+2 via FETCH_HI.
    - `instr` = {next_word[15:0], cur_word[31:16]}.
    - The buffer then holds the second word.
  - Buffer hit (tag == pc[31:2], valid): the FETCH bus read is skipped and the buffered word is used.
- `FWRISC_FETCH_COMPRESSED_EN` undefined:
  - `next_pc[1:0]` is forced to 0.
  - `instr_c`=0 always.
  - Every fetch performs one bus read; FETCH_HI and the buffer are not built.

## Test plan
- Reset, `iready`=1, `idata`=32'h0000_0013 -> `iaddr`=32'h8000_0000 in the first post-reset cycle; `fetch_valid`=1 next cycle with `instr`=32'h0000_0013, `pc`=32'h8000_0000, `instr_c`=0.
- `iready` held low for 5 cycles -> `ivalid`=1 and `iaddr` unchanged throughout; `fetch_valid` rises one cycle after `iready`.
- `decode_ready` and `next_pc_valid`(32'h8000_0004) in the same HOLD cycle -> `fetch_valid`=0 next cycle with `ivalid`=1, `iaddr`=32'h8000_0004.
- `next_pc_valid` pulsed during FETCH -> ignored; `pc` unchanged; no extra bus request.
- COMPRESSED_EN:
  - Word 32'h4501_4505 at 32'h8000_0000 -> pc=0: `instr`=32'h0000_4505, `instr_c`=1.
  - Then next_pc=32'h8000_0002 -> no bus cycle; `instr`=32'h0000_4501.
- COMPRESSED_EN split: pc=32'h8000_0002, words 32'h0093_0000 and 32'h1234_0000 -> two bus reads (0x8000_0000, 0x8000_0004); `instr`=32'h0000_0093, `instr_c`=0.
- Reset asserted while `ivalid`=1 and `iready`=1 -> `ivalid`=0 and `fetch_valid`=0 next cycle; restart fetch at RESET_VECTOR.
